// File: rtl/mul_pkg.sv
// Shared definitions for the multiply-accumulate stage: FSM encoding and
// saturation limits derived from an accumulator width.
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } state_e;

    // Limits are returned as 64-bit patterns; callers truncate to their width.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational signed add of a narrow addend into an accumulator value,
// clamped to the accumulator range with an overflow indication.
module sat_adder
    import mul_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned IN_WIDTH  = 12
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [IN_WIDTH-1:0]  addend,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);

    localparam logic [ACC_WIDTH-1:0] SatMax = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SatMin = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic [ACC_WIDTH:0] acc_ext;
    logic [ACC_WIDTH:0] add_ext;
    logic [ACC_WIDTH:0] raw;

    always_comb begin
        acc_ext = {acc[ACC_WIDTH-1], acc};
        add_ext = {{(ACC_WIDTH + 1 - IN_WIDTH){addend[IN_WIDTH-1]}}, addend};
        raw     = acc_ext + add_ext;
        // One guard bit suffices: the top two bits differ only when out of range.
        ovf     = raw[ACC_WIDTH] ^ raw[ACC_WIDTH-1];
        if (!ovf) begin
            sum = raw[ACC_WIDTH-1:0];
        end else if (raw[ACC_WIDTH]) begin
            sum = SatMin;
        end else begin
            sum = SatMax;
        end
    end

endmodule

// File: rtl/mul_acc_stage.sv
// Registered saturating accumulator for a stream of signed products; presents
// sum, count and sticky overflow per burst over a valid/ready output.
module mul_acc_stage
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_prod,
    input  logic                 in_last,
    input  logic                 clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_ovf
);

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;
    logic                 accept;
    logic                 out_fire;

    sat_adder #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_WIDTH  (2 * WIDTH)
    ) u_sat_adder (
        .acc    (acc_q),
        .addend (in_prod),
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StAcc: begin
                if (accept) begin
                    state_d = in_last ? StHold : StAcc;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        in_ready  = (state_q != StHold);
        out_valid = (state_q == StHold);
    end

    // Datapath next state; clr wins over both handshakes.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr || out_fire) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            acc_d = add_sum;
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
            ovf_d = ovf_q | add_ovf;
        end
    end

    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul_acc_stage.sv
// Bench for mul_acc_stage: three instances (16-bit, 12-bit accumulator, 2-bit
// counter) share one input stream and are checked against an integer model.
module tb_mul_acc_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        clr = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_prod = '0;

    logic        ir16, ir12, ir2, ov16, ov12, ov2, f16, f12, f2;
    logic [15:0] s16, s2;
    logic [11:0] s12;
    logic [7:0]  c16, c12;
    logic [1:0]  c2;

    int nchecks = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mul_acc_stage #(.WIDTH(6), .ACC_WIDTH(16), .CNT_W(8)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .in_prod(in_prod),
        .in_last(in_last), .clr(clr), .out_valid(ov16), .out_ready(out_ready),
        .out_sum(s16), .out_count(c16), .out_ovf(f16)
    );
    mul_acc_stage #(.WIDTH(6), .ACC_WIDTH(12), .CNT_W(8)) u12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir12), .in_prod(in_prod),
        .in_last(in_last), .clr(clr), .out_valid(ov12), .out_ready(out_ready),
        .out_sum(s12), .out_count(c12), .out_ovf(f12)
    );
    mul_acc_stage #(.WIDTH(6), .ACC_WIDTH(16), .CNT_W(2)) uc2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_prod(in_prod),
        .in_last(in_last), .clr(clr), .out_valid(ov2), .out_ready(out_ready),
        .out_sum(s2), .out_count(c2), .out_ovf(f2)
    );

    // Reference model: plain integers, one slot per instance.
    int amax [3] = '{32767, 2047, 32767};
    int cmax [3] = '{255, 255, 3};
    int macc [3];
    int mcnt [3];
    bit mov [3];
    bit mhold;
    int p;
    assign p = int'($signed(in_prod));

    function automatic int clamp(input int v, input int mx);
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clr || (mhold && out_ready)) begin
            for (int i = 0; i < 3; i++) begin
                macc[i] <= 0;
                mcnt[i] <= 0;
                mov[i]  <= 1'b0;
            end
            mhold <= 1'b0;
        end else if (!mhold && in_valid) begin
            for (int i = 0; i < 3; i++) begin
                macc[i] <= clamp(macc[i] + p, amax[i]);
                mov[i]  <= mov[i] | (macc[i] + p > amax[i]) | (macc[i] + p < -amax[i] - 1);
                mcnt[i] <= (mcnt[i] == cmax[i]) ? mcnt[i] : mcnt[i] + 1;
            end
            mhold <= in_last;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input string tag, input int i, input logic ir, input logic ovl,
                            input int sum, input int cnt, input logic of);
        chk({tag, ".in_ready"}, int'(ir), int'(!mhold));
        chk({tag, ".out_valid"}, int'(ovl), int'(mhold));
        chk({tag, ".out_sum"}, sum, macc[i]);
        chk({tag, ".out_count"}, cnt, mcnt[i]);
        chk({tag, ".out_ovf"}, int'(of), int'(mov[i]));
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk_inst("a16", 0, ir16, ov16, int'($signed(s16)), int'(c16), f16);
            chk_inst("a12", 1, ir12, ov12, int'($signed(s12)), int'(c12), f12);
            chk_inst("c2", 2, ir2, ov2, int'($signed(s2)), int'(c2), f2);
        end
    end

    typedef struct packed {
        logic [4:0][11:0] prods;
        int               n;
        int               sum16;
        int               sum12;
        int               cnt8;
        int               cnt2;
        logic             ovf16;
        logic             ovf12;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Feed one table burst; returns in the cycle after the last accept.
    task automatic burst(input int k, input logic ordy);
        for (int j = 0; j < vecs[k].n; j++) begin
            in_valid  = 1'b1;
            in_prod   = vecs[k].prods[j];
            in_last   = (j == vecs[k].n - 1);
            out_ready = ordy;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk($sformatf("v%0d.out_valid", k), int'(ov16), 1);
        chk($sformatf("v%0d.sum16", k), int'($signed(s16)), vecs[k].sum16);
        chk($sformatf("v%0d.sum12", k), int'($signed(s12)), vecs[k].sum12);
        chk($sformatf("v%0d.cnt8", k), int'(c16), vecs[k].cnt8);
        chk($sformatf("v%0d.cnt2", k), int'(c2), vecs[k].cnt2);
        chk($sformatf("v%0d.ovf16", k), int'(f16), int'(vecs[k].ovf16));
        chk($sformatf("v%0d.ovf12", k), int'(f12), int'(vecs[k].ovf12));
    endtask

    initial begin
        vecs[0] = '{prods: {12'd0, 12'd0, 12'd961, 12'(-30), 12'd100},
                    n: 3, sum16: 1031, sum12: 1031, cnt8: 3, cnt2: 3, ovf16: 0, ovf12: 0};
        vecs[1] = '{prods: {12'd0, 12'd0, 12'd961, 12'd961, 12'd961},
                    n: 3, sum16: 2883, sum12: 2047, cnt8: 3, cnt2: 3, ovf16: 0, ovf12: 1};
        vecs[2] = '{prods: {12'd0, 12'd0, 12'(-961), 12'(-961), 12'(-961)},
                    n: 3, sum16: -2883, sum12: -2048, cnt8: 3, cnt2: 3, ovf16: 0, ovf12: 1};
        vecs[3] = '{prods: {12'd1, 12'd1, 12'd1, 12'd1, 12'd1},
                    n: 5, sum16: 5, sum12: 5, cnt8: 5, cnt2: 3, ovf16: 0, ovf12: 0};
        vecs[4] = '{prods: {12'd0, 12'(-961), 12'd961, 12'd961, 12'd961},
                    n: 4, sum16: 1922, sum12: 1086, cnt8: 4, cnt2: 3, ovf16: 0, ovf12: 1};

        #1 rst = 1'b1;
        #12 rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("reset.in_ready", int'(ir16), 1);
        chk("reset.out_valid", int'(ov16), 0);
        chk("reset.out_sum", int'(s16), 0);
        chk("reset.out_count", int'(c16), 0);
        chk("reset.out_ovf", int'(f16), 0);

        // Table bursts, consumer always ready.
        for (int k = 0; k < 5; k++) begin
            burst(k, 1'b1);
            tick();
            chk($sformatf("v%0d.in_ready_after", k), int'(ir16), 1);
            chk($sformatf("v%0d.valid_after", k), int'(ov16), 0);
        end

        // Result held under backpressure while upstream keeps offering a product.
        burst(0, 1'b0);
        in_valid = 1'b1;
        in_prod  = 12'd7;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold.in_ready", int'(ir16), 0);
            chk("hold.out_valid", int'(ov16), 1);
            chk("hold.out_sum", int'($signed(s16)), 1031);
            chk("hold.out_count", int'(c16), 3);
        end
        out_ready = 1'b1;
        tick();
        chk("hold.release_ready", int'(ir16), 1);
        chk("hold.release_valid", int'(ov16), 0);
        tick();
        chk("hold.next_valid", int'(ov16), 1);
        chk("hold.next_sum", int'($signed(s16)), 7);
        chk("hold.next_count", int'(c16), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();

        // clr in ACC coinciding with an accept.
        in_valid = 1'b1;
        in_prod  = 12'd50;
        tick();
        in_prod = 12'd60;
        tick();
        in_prod = 12'd70;
        clr     = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr.in_ready", int'(ir16), 1);
        chk("clr.out_sum", int'(s16), 0);
        chk("clr.out_count", int'(c16), 0);
        in_valid = 1'b1;
        in_prod  = 12'd5;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("clr.single_valid", int'(ov16), 1);
        chk("clr.single_sum", int'($signed(s16)), 5);
        chk("clr.single_count", int'(c16), 1);
        tick();

        // Asynchronous reset mid-cycle while holding a saturated result.
        burst(1, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst.valid16", int'(ov16), 0);
        chk("arst.valid12", int'(ov12), 0);
        chk("arst.in_ready", int'(ir16), 1);
        chk("arst.sum16", int'(s16), 0);
        chk("arst.sum12", int'(s12), 0);
        chk("arst.count", int'(c16), 0);
        chk("arst.ovf12", int'(f12), 0);
        #1 rst = 1'b0;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_prod   = 12'($urandom_range(0, 2047)) - 12'd1024;
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 29) == 0);
            tick();
        end
        in_valid = 1'b0;
        clr      = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/mul_acc_stage.md
# mul_acc_stage

Downstream consumer of the signed `width`-bit multiplier. It accepts a stream of two's-complement products over a valid/ready handshake and accumulates them into a saturating `ACC_WIDTH`-bit sum. At the end of each burst it presents the sum, product count and an overflow flag on an output valid/ready handshake. It turns the combinational multiplier into a registered multiply-accumulate datapath for the display and readout stages.

## Interface
- `WIDTH`, 6: operand width of the upstream multiplier; the product is `2*WIDTH` bits.
- `ACC_WIDTH`, 16: accumulator width; must be ≥ `2*WIDTH`.
- `CNT_W`, 8: product-counter width.
- `clk` input, 1: the only clock; all state changes on its rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `in_valid` input, 1: `in_prod` and `in_last` are valid.
- `in_ready` output, 1: the stage can accept a product.
- `in_prod` input, `2*WIDTH`: signed two's-complement product.
- `in_last` input, 1: this product closes the burst.
- `clr` input, 1: synchronous abort. Discards the burst and any held result.
- `out_valid` output, 1: the result is held and valid.
- `out_ready` input, 1: the consumer takes the result.
- `out_sum` output, `ACC_WIDTH`: signed, saturated burst sum.
- `out_count` output, `CNT_W`: number of products accepted in the burst, saturating at all-ones.
- `out_ovf` output, 1: saturation occurred at least once in the burst (sticky for the burst).

## Operation
- States: IDLE (no product accepted yet), ACC (burst in progress), HOLD (result presented).
- A product is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and ACC, 0 in HOLD. It is decoded from state only, with no combinational path from `out_ready`.
- Accept without `in_last`: the accumulator updates and the state goes to ACC.
- Accept with `in_last`: the accumulator updates and the state goes to HOLD. A single-product burst goes IDLE→HOLD.
- HOLD: `out_valid` = 1, and `out_sum`, `out_count`, `out_ovf` are stable.
- When `out_valid && out_ready`: the accumulator, count and ovf clear, and the state goes to IDLE.
- Arithmetic:
  - Sign-extend `in_prod` and `acc` to `ACC_WIDTH+1` bits and add.
  - If the result exceeds 2^(ACC_WIDTH-1)−1, load the positive maximum and set ovf.
  - If the result is below −2^(ACC_WIDTH-1), load the negative minimum and set ovf.
  - Saturation is applied per add. Later adds continue from the clamped value.
- Count: increments per accepted product and holds at 2^CNT_W−1 (this does not set ovf).
- `clr` has top priority. The next state is IDLE with acc/count/ovf = 0, whether the block is in ACC, in HOLD, or `clr` coincides with an accept or an output handshake. The product offered in that cycle is dropped.
- `in_valid` in HOLD is ignored. Upstream must hold the product (standard handshake).

## Timing
- Reset values: `out_valid` 0, `out_sum` 0, `out_count` 0, `out_ovf` 0, state IDLE, so `in_ready` 1.
- Reset mid-burst or in HOLD discards everything immediately (asynchronously).
- Throughput: one product per cycle in IDLE/ACC.
- Latency: `out_valid` rises the cycle after the `in_last` accept edge. `out_sum` already includes that product.
- The earliest next accept is the cycle after the output handshake, so there is a minimum 1-cycle bubble between bursts.
- `out_sum`, `out_count` and `out_ovf` are driven directly from the registers and are meaningful only while `out_valid` = 1. Outside HOLD they show the running values.

## Structure
- Shared package `mul_pkg`: the state encoding (IDLE/ACC/HOLD) and the saturation limit constants derived from `ACC_WIDTH`.
- Sub-module `sat_adder` (parameter `ACC_WIDTH`, `IN_WIDTH`): combinational sign-extend, add, clamp, and overflow out.
- The top level holds the FSM, the registers and the counter.

## Test plan
1. `WIDTH`=6, `ACC_WIDTH`=16. Products 100, −30, 961 (last), with `out_ready`=1 → `out_valid` one cycle after the last accept. Expect `out_sum`=1031, `out_count`=3, `out_ovf`=0, and `in_ready` back to 1 the next cycle.
2. `ACC_WIDTH`=12. Products 961 ×3 (last on the 3rd) → `out_sum`=2047, `out_ovf`=1. Repeat with −961 ×3 → `out_sum`=−2048, `out_ovf`=1.
3. Burst result held with `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0, outputs stable. `out_ready`=1 → the held product is accepted the following cycle.
4. `clr` asserted in ACC after 2 products, in the same cycle as an accepted product → state IDLE, acc=0, `count`=0. The next burst of a single product 5 (last) gives `out_sum`=5, `out_count`=1.
5. `rst` pulsed asynchronously mid-cycle during HOLD → `out_valid` drops at once and all outputs are 0.
6. `CNT_W`=2. Five products of 1 → `out_count`=3, `out_sum`=5, `out_ovf`=0.
